// File: rtl/div_restore_iter_if.sv
// Handshake and operand/result bundle for the iterative restoring divider.
// The requester uses the master view; the divider uses the slave view.
interface div_restore_iter_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quot;
  logic [VW-1:0] rem;
  logic          busy;
  logic          done;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  quot, rem, busy, done, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output quot, rem, busy, done, dz
  );
endinterface

// File: rtl/div_restore_iter.sv
// Unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// A zero divisor never enters CALC; the saturated result is posted on the following edge.
module div_restore_iter #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic               clk,
  input  logic               clr,
  div_restore_iter_if.slave  bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  logic [VW:0]   pr_r;
  logic [DW-1:0] q_r;
  logic [CW-1:0] cnt_r;
  logic          zpend_r;
  logic [DW-1:0] quot_r;
  logic [VW-1:0] rem_r;
  logic          busy_r, done_r, dz_r;

  logic          load_s, zero_s, step_s, fin_s;
  logic [VW:0]   pr_shift_s, pr_step_s;
  logic          qbit_s;
  logic [DW-1:0] q_step_s;

  assign bus.quot = quot_r;
  assign bus.rem  = rem_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_r;

  // Next-state and control decode; starts are only honoured in IDLE with no zero-divide pending
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    zero_s  = 1'b0;
    step_s  = 1'b0;
    fin_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !zpend_r) begin
          if (bus.divisor != {VW{1'b0}}) begin
            load_s  = 1'b1;
            state_s = CALC;
          end else begin
            zero_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (cnt_r == {CW{1'b0}}) begin
          fin_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = CALC;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    pr_shift_s = {pr_r[VW-1:0], dvd_r[DW-1]};
    if (pr_shift_s >= {1'b0, dvs_r}) begin
      qbit_s    = 1'b1;
      pr_step_s = pr_shift_s - {1'b0, dvs_r};
    end else begin
      qbit_s    = 1'b0;
      pr_step_s = pr_shift_s;
    end
    q_step_s = {q_r[DW-2:0], qbit_s};
  end

  // State, datapath and result registers; clr aborts everything without a done
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      dvd_r   <= {DW{1'b0}};
      dvs_r   <= {VW{1'b0}};
      pr_r    <= {(VW+1){1'b0}};
      q_r     <= {DW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      zpend_r <= 1'b0;
      quot_r  <= {DW{1'b0}};
      rem_r   <= {VW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      zpend_r <= zero_s;
      if (load_s) begin
        dvd_r  <= bus.dividend;
        dvs_r  <= bus.divisor;
        pr_r   <= {(VW+1){1'b0}};
        q_r    <= {DW{1'b0}};
        cnt_r  <= CW'(DW - 1);
        busy_r <= 1'b1;
      end else if (step_s) begin
        dvd_r <= {dvd_r[DW-2:0], 1'b0};
        pr_r  <= pr_step_s;
        q_r   <= q_step_s;
        cnt_r <= cnt_r - 1'b1;
        if (fin_s) begin
          quot_r <= q_step_s;
          rem_r  <= pr_step_s[VW-1:0];
          dz_r   <= 1'b0;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          busy_r <= 1'b1;
        end
      end else if (zpend_r) begin
        quot_r <= {DW{1'b1}};
        rem_r  <= {VW{1'b0}};
        dz_r   <= 1'b1;
        done_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
      end
    end
  end
endmodule

// File: tb/tb_div_restore_iter.sv
// Self-checking bench for div_restore_iter: directed cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_div_restore_iter;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_restore_iter_if #(.DW(DW), .VW(VW)) bus ();

  div_restore_iter #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: quotient/remainder straight from / and %, saturated result on zero divisor
  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r, output logic z);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = 8'hFF; r = 4'h0; z = 1'b1;
    end else begin
      q = 8'(ai / bi); r = 4'(ai % bi); z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division; report edges from the start edge to done and busy cycles seen
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int bcnt, output bit both);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    lat  = -1;
    bcnt = 0;
    both = 1'b0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (k > 0) tick();
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) both = 1'b1;
      if (bus.done) lat = k;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.start = 1'b1; bus.dividend = 8'd25; bus.divisor = 4'd5;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy cyc%0d got=%b exp=0", i, bus.busy);
      end
    end
    n_checks++;
    if ({bus.quot, bus.rem, bus.done, bus.dz} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs got q=%0d r=%0d done=%b dz=%b exp all 0",
                         bus.quot, bus.rem, bus.done, bus.dz);
    end
    clr = 1'b0; bus.start = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_lost got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
  endtask

  // Directed and random divisions: result, done latency, busy length, busy/done exclusion
  task automatic test_divide(input string tag, input int n, input logic [7:0] av[], input logic [3:0] bv[]);
    logic [7:0] eq; logic [3:0] er; logic ez;
    int lat, bcnt; bit both;
    for (int i = 0; i < n; i++) begin
      model(av[i], bv[i], eq, er, ez);
      run_div(av[i], bv[i], lat, bcnt, both);
      n_checks++;
      if (bus.quot !== eq || bus.rem !== er || bus.dz !== ez) begin
        n_fail++; $display("FAIL %s_result %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b",
                           tag, av[i], bv[i], bus.quot, bus.rem, bus.dz, eq, er, ez);
      end
      n_checks++;
      if (lat != (ez ? 1 : DW) || bcnt != (ez ? 0 : DW) || both) begin
        n_fail++; $display("FAIL %s_timing %0d/%0d got lat=%0d busy=%0d both=%b exp lat=%0d busy=%0d both=0",
                           tag, av[i], bv[i], lat, bcnt, both, ez ? 1 : DW, ez ? 0 : DW);
      end
      tick();
    end
  endtask

  task automatic test_protocol();
    int lat = -1;
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      if (k > 0) tick();
      if (k == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd30; bus.divisor = 4'd4;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) lat = k;
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat != DW || bus.quot !== 8'd28 || bus.rem !== 4'd4) begin
      n_fail++; $display("FAIL protocol_ignore_start got lat=%0d q=%0d r=%0d exp lat=%0d q=28 r=4",
                         lat, bus.quot, bus.rem, DW);
    end
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done || bus.busy) lat++;
    end
    n_checks++;
    if (lat != 0) begin
      n_fail++; $display("FAIL protocol_no_queue got active_cycles=%0d exp 0", lat);
    end
  endtask

  task automatic test_abort();
    int dones = 0, lat, bcnt; bit both;
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if ({bus.quot, bus.rem, bus.busy, bus.done, bus.dz} !== 15'd0) begin
      n_fail++; $display("FAIL abort_clear got q=%0d r=%0d busy=%b done=%b dz=%b exp all 0",
                         bus.quot, bus.rem, bus.busy, bus.done, bus.dz);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort_no_done got dones=%0d exp 0", dones);
    end
    run_div(8'd30, 8'd4, lat, bcnt, both);
    n_checks++;
    if (lat != DW || bus.quot !== 8'd7 || bus.rem !== 4'd2 || bus.dz !== 1'b0) begin
      n_fail++; $display("FAIL abort_restart got lat=%0d q=%0d r=%0d dz=%b exp lat=%0d q=7 r=2 dz=0",
                         lat, bus.quot, bus.rem, bus.dz, DW);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int seen[$];
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) begin
        seen.push_back(c);
        n_checks++;
        if (bus.quot !== 8'd28 || bus.rem !== 4'd4) begin
          n_fail++; $display("FAIL b2b_result cyc%0d got q=%0d r=%0d exp q=28 r=4", c, bus.quot, bus.rem);
        end
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (seen.size() != 4) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (seen[i] != DW + i * (DW + 1)) begin
          n_fail++; $display("FAIL b2b_spacing done%0d got cyc=%0d exp cyc=%0d", i, seen[i], DW + i * (DW + 1));
        end
      end
    end
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_loopback();
    logic [7:0] av[]; logic [3:0] bv[];
    av = new[10]; bv = new[10];
    for (int i = 0; i < 10; i++) begin
      av[i] = 8'((i + 5) * (i + 5));
      bv[i] = 4'(i + 5);
    end
    test_divide("loop", 10, av, bv);
  endtask

  initial begin
    logic [7:0] av[]; logic [3:0] bv[];
    bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 4'd0; clr = 1'b1;
    test_reset();
    av = '{8'd25, 8'd200, 8'd255};             bv = '{4'd5, 4'd7, 4'd15};
    test_divide("basic", 3, av, bv);
    av = '{8'd9, 8'd0, 8'd255};                bv = '{4'd10, 4'd3, 4'd1};
    test_divide("edge", 3, av, bv);
    av = '{8'd100, 8'd30};                     bv = '{4'd0, 4'd4};
    test_divide("dz", 2, av, bv);
    test_protocol();
    test_abort();
    test_back_to_back();
    test_loopback();
    av = new[24]; bv = new[24];
    for (int i = 0; i < 24; i++) begin
      av[i] = 8'($urandom);
      bv[i] = (i % 8 == 7) ? 4'd0 : 4'($urandom);
    end
    test_divide("rand", 24, av, bv);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
